inst_sequencer: RTL and testbench
=================================

INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of program words (the PC is log2(DEPTH) = 4 bits).
REQ-002 The block SHALL have parameter NOP_INST, default 8'h3F, meaning the instruction driven when idle (no load, no bus driver on the micro).
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock, with all logic on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: a synchronous, active-low reset.
REQ-005 The block SHALL have port prog_we, input, 1 bit: program memory write strobe.
REQ-006 The block SHALL have port prog_addr, input, 4 bits: program write address.
REQ-007 The block SHALL have port prog_inst, input, 8 bits: instruction byte to write.
REQ-008 The block SHALL have port prog_data, input, 8 bits: immediate data byte to write.
REQ-009 The block SHALL have port prog_last, input, 1 bit: end-of-program flag written with the word.
REQ-010 The block SHALL have port start, input, 1 bit: a single-cycle run request.
REQ-011 The block SHALL have port step, input, 1 bit: a single-cycle request to issue one word.
REQ-012 The block SHALL have port stop, input, 1 bit: a single-cycle halt request.
REQ-013 The block SHALL have port inst, output, 8 bits: registered instruction to the micro.
REQ-014 The block SHALL have port data_in, output, 8 bits: registered immediate to the micro's data_in.
REQ-015 The block SHALL have port pc, output, 4 bits: address of the next word to issue.
REQ-016 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-017 The block SHALL have port done, output, 1 bit: high while in DONE.

Function
REQ-018 Program memory SHALL hold DEPTH words of {last, inst[7:0], data[7:0]} (17 bits).
REQ-019 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-020 Request priority SHALL be stop > start > step when several requests are asserted in the same cycle.
REQ-021 In IDLE, start SHALL move the FSM to RUN with pc unchanged, so execution resumes.
REQ-022 In DONE, start SHALL set pc to 0 and move the FSM to RUN.
REQ-023 In RUN, each cycle SHALL load inst and data_in from mem[pc] at the next edge and set pc to pc+1 (modulo DEPTH), giving 1-cycle latency from pc to inst.
REQ-024 In RUN, an issued word with last=1 SHALL move the FSM to DONE and set pc to pc+1 (modulo DEPTH); inst SHALL be NOP_INST from the following cycle onward.
REQ-025 In RUN, stop SHALL move the FSM to IDLE; no word SHALL be issued that cycle, inst SHALL become NOP_INST and pc SHALL hold.
REQ-026 In IDLE, step SHALL issue mem[pc] for exactly one cycle and set pc to pc+1; if that word's last=1, the FSM SHALL go to DONE, otherwise it SHALL stay in IDLE.
REQ-027 In DONE, step SHALL be ignored.
REQ-028 inst SHALL equal NOP_INST and data_in SHALL hold its prior value in every cycle in which no word is issued.
REQ-029 When pc is 15 and the issued word has last=0, pc SHALL wrap to 0 and RUN SHALL continue without a flag.
REQ-030 prog_we SHALL be accepted in IDLE and DONE only, and ignored in RUN.
REQ-031 A write to the address being issued in the same cycle SHALL issue the old contents (read-before-write).
REQ-032 busy SHALL be registered and equal (state==RUN); done SHALL be registered and equal (state==DONE).

Reset
REQ-033 While rst_n is low at a clock edge, the block SHALL set: state to IDLE, pc to 0, inst to NOP_INST, data_in to 8'h00, busy to 0, done to 0.
REQ-034 Reset asserted mid-RUN SHALL abort with no further words issued, starting from the edge at which rst_n is sampled low.
REQ-035 Program memory contents SHALL NOT be reset and SHALL be retained across rst_n.

Structure
REQ-036 Package inst_seq_pkg SHALL hold the state enum (IDLE, RUN, DONE), the DEPTH default, the NOP_INST default, and a typedef for the 17-bit program word.
REQ-037 The memory SHALL be one sub-module, seq_prog_mem: 1 write port and 1 read port, with an asynchronous or combinational read of mem[pc].

Verification
REQ-038 The bench SHALL cover: write 3 words {0,8'h01,8'h00}, {0,8'h40,8'h05}, {1,8'h48,8'h00}, then pulse start -> inst is 01, 40, 48 on three consecutive cycles; data_in=05 on the second cycle; then DONE with done=1, inst=3F and pc=3.
REQ-039 The bench SHALL cover: pulse stop during the second issued word of a 4-word program -> inst=3F next cycle, busy=0, pc=2; then pulse start -> resumes with mem[2].
REQ-040 The bench SHALL cover: in IDLE with pc=0, three step pulses -> each issues exactly one word, pc counts 1, 2, 3, and inst=3F between steps.
REQ-041 The bench SHALL cover: all 16 words written with last=0 -> pc wraps from 15 to 0 and mem[0] is reissued on the cycle after mem[15].
REQ-042 The bench SHALL cover: start and stop in the same IDLE cycle -> FSM stays in IDLE; prog_we during RUN -> memory unchanged (verified by readback through step).
REQ-043 The bench SHALL cover: rst_n low for 1 cycle mid-RUN -> next cycle inst=3F, pc=0, busy=0; memory retained (a following start reissues the same program).

Source files
------------

// File: rtl/inst_seq_pkg.sv
// rtl/inst_seq_pkg.sv - shared types and defaults for the instruction sequencer
package inst_seq_pkg;

  localparam int         DEPTH_DEF    = 16;
  localparam logic [7:0] NOP_INST_DEF = 8'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] inst;
    logic [7:0] data;
  } prog_word_t;

endpackage

// File: rtl/inst_seq_if.sv
// rtl/inst_seq_if.sv - program load, run control and micro-facing outputs of the sequencer
interface inst_seq_if #(
  parameter int AW = 4
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_inst;
  logic [7:0]    prog_data;
  logic          prog_last;
  logic          start;
  logic          step;
  logic          stop;
  logic [7:0]    inst;
  logic [7:0]    data_in;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  modport master (
    output prog_we, prog_addr, prog_inst, prog_data, prog_last, start, step, stop,
    input  inst, data_in, pc, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_inst, prog_data, prog_last, start, step, stop,
    output inst, data_in, pc, busy, done
  );
endinterface

// File: rtl/seq_prog_mem.sv
// rtl/seq_prog_mem.sv - program store, one write port and one combinational read port, never reset
module seq_prog_mem
  import inst_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [AW-1:0] i_waddr,
  input  prog_word_t i_wdata,
  input  logic [AW-1:0] i_raddr,
  output prog_word_t o_rdata
);

  prog_word_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Combinational read sees the pre-edge contents, so a same-cycle write issues old data.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - feeds program words to the micro under start/step/stop control
module inst_sequencer
  import inst_seq_pkg::*;
#(
  parameter int         DEPTH    = DEPTH_DEF,
  parameter logic [7:0] NOP_INST = NOP_INST_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  inst_seq_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] w_pc_inc;
  logic [7:0]    r_inst;
  logic [7:0]    r_data;
  logic          r_busy;
  logic          r_done;
  logic          w_issue;
  logic          w_we;
  prog_word_t    w_wword;
  prog_word_t    w_rword;

  assign w_we     = bus.prog_we && (r_state != RUN);
  assign w_wword  = '{last: bus.prog_last, inst: bus.prog_inst, data: bus.prog_data};
  assign w_pc_inc = (r_pc == AW'(DEPTH - 1)) ? '0 : r_pc + 1'b1;

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (bus.prog_addr),
    .i_wdata (w_wword),
    .i_raddr (r_pc),
    .o_rdata (w_rword)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.stop) begin
          w_state_nxt = IDLE;
        end else if (bus.start) begin
          w_state_nxt = RUN;
        end else if (bus.step) begin
          w_issue  = 1'b1;
          w_pc_nxt = w_pc_inc;
          if (w_rword.last) w_state_nxt = DONE;
        end
      end
      RUN: begin
        if (bus.stop) begin
          w_state_nxt = IDLE;
        end else begin
          w_issue  = 1'b1;
          w_pc_nxt = w_pc_inc;
          if (w_rword.last) w_state_nxt = DONE;
        end
      end
      DONE: begin
        // stop outranks start here too, so start+stop leaves the finished program alone.
        if (!bus.stop && bus.start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_inst  <= NOP_INST;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_issue ? w_rword.inst : NOP_INST;
      if (w_issue) r_data <= w_rword.data;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  assign bus.inst    = r_inst;
  assign bus.data_in = r_data;
  assign bus.pc      = r_pc;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - directed checks of run, stop, step, wrap, write gating and reset
module tb_inst_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  inst_seq_if #(.AW(4)) bus ();

  inst_sequencer #(
    .DEPTH    (16),
    .NOP_INST (8'h3F)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [3:0] a, input logic l, input logic [7:0] i, input logic [7:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_last = l;
    bus.prog_inst = i;
    bus.prog_data = d;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_step();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_inst = '0; bus.prog_data = '0;
    bus.prog_last = 1'b0; bus.start = 1'b0; bus.step = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_inst", bus.inst, 8'h3F);
    check("rst_data", bus.data_in, 8'h00);
    check("rst_pc", bus.pc, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);

    // Three-word program run from IDLE
    write_word(4'd0, 1'b0, 8'h01, 8'h00);
    write_word(4'd1, 1'b0, 8'h40, 8'h05);
    write_word(4'd2, 1'b1, 8'h48, 8'h00);
    pulse_start();
    check("run_busy", bus.busy, 1);
    check("run_nop_before", bus.inst, 8'h3F);
    tick();
    check("run_i0", bus.inst, 8'h01);
    check("run_pc1", bus.pc, 1);
    tick();
    check("run_i1", bus.inst, 8'h40);
    check("run_d1", bus.data_in, 8'h05);
    tick();
    check("run_i2", bus.inst, 8'h48);
    check("run_done_early", bus.done, 1);
    tick();
    check("done_inst", bus.inst, 8'h3F);
    check("done_flag", bus.done, 1);
    check("done_busy", bus.busy, 0);
    check("done_pc", bus.pc, 3);
    check("done_data_hold", bus.data_in, 8'h00);

    // Four-word program, stop during second word, then resume
    write_word(4'd0, 1'b0, 8'h11, 8'hA1);
    write_word(4'd1, 1'b0, 8'h22, 8'hA2);
    write_word(4'd2, 1'b0, 8'h33, 8'hA3);
    write_word(4'd3, 1'b1, 8'h44, 8'hA4);
    pulse_start();
    check("restart_pc", bus.pc, 0);
    check("restart_busy", bus.busy, 1);
    tick();
    check("s_i0", bus.inst, 8'h11);
    tick();
    check("s_i1", bus.inst, 8'h22);
    pulse_stop();
    check("stop_inst", bus.inst, 8'h3F);
    check("stop_busy", bus.busy, 0);
    check("stop_pc", bus.pc, 2);
    check("stop_data_hold", bus.data_in, 8'hA2);
    pulse_start();
    check("resume_nop", bus.inst, 8'h3F);
    tick();
    check("resume_i2", bus.inst, 8'h33);
    check("resume_d2", bus.data_in, 8'hA3);
    check("resume_pc", bus.pc, 3);
    tick();
    check("resume_i3", bus.inst, 8'h44);
    check("resume_done", bus.done, 1);

    // Single stepping from IDLE, pc=0
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pulse_step();
      check("step_inst", bus.inst, 32'h11 * (k + 1));
      check("step_pc", bus.pc, k + 1);
      check("step_busy", bus.busy, 0);
      tick();
      check("step_gap", bus.inst, 8'h3F);
    end
    pulse_step();
    check("step_last", bus.inst, 8'h44);
    check("step_last_done", bus.done, 1);
    pulse_step();
    check("step_in_done", bus.inst, 8'h3F);
    check("step_in_done_pc", bus.pc, 4);

    // start and stop together in IDLE; write attempt while running
    do_reset();
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("ss_busy", bus.busy, 0);
    check("ss_pc", bus.pc, 0);
    check("ss_inst", bus.inst, 8'h3F);
    pulse_start();
    write_word(4'd3, 1'b0, 8'hEE, 8'hEE);
    check("we_run_i0", bus.inst, 8'h11);
    pulse_stop();
    check("we_run_stop_pc", bus.pc, 1);
    pulse_step();
    pulse_step();
    pulse_step();
    check("we_run_readback", bus.inst, 8'h44);
    check("we_run_rb_data", bus.data_in, 8'hA4);
    check("we_run_rb_done", bus.done, 1);

    // Reset mid-run aborts; program is retained
    do_reset();
    pulse_start();
    tick();
    tick();
    check("mid_i1", bus.inst, 8'h22);
    do_reset();
    check("mid_rst_inst", bus.inst, 8'h3F);
    check("mid_rst_pc", bus.pc, 0);
    check("mid_rst_busy", bus.busy, 0);
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_reissue", bus.inst, 32'h11 * (k + 1));
    end
    check("mid_reissue_done", bus.done, 1);

    // Write to the word being stepped issues old contents
    do_reset();
    bus.step = 1'b1;
    write_word(4'd0, 1'b0, 8'h55, 8'h66);
    bus.step = 1'b0;
    check("rbw_old", bus.inst, 8'h11);
    check("rbw_pc", bus.pc, 1);
    do_reset();
    pulse_step();
    check("rbw_new", bus.inst, 8'h55);
    check("rbw_new_data", bus.data_in, 8'h66);

    // All words non-last: pc wraps and RUN continues
    for (int k = 0; k < 16; k++) write_word(4'(k), 1'b0, 8'(8'h80 + k), 8'(k));
    do_reset();
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      tick();
      check("wrap_inst", bus.inst, 8'h80 + k);
    end
    check("wrap_pc0", bus.pc, 0);
    check("wrap_busy", bus.busy, 1);
    tick();
    check("wrap_reissue", bus.inst, 8'h80);
    check("wrap_pc1", bus.pc, 1);
    check("wrap_no_done", bus.done, 0);
    pulse_stop();
    check("wrap_stop_inst", bus.inst, 8'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
